// File: rtl/warp_issue_queue_pkg.sv
// Shared constants for the warp bundle issue queue.
// Bundles are opaque here; the real bundle width comes from the decode/issue defines.
package warp_issue_queue_pkg;

  localparam int unsigned BundleWDefault = 64;
  localparam int unsigned DepthDefault   = 8;
  // Decode always delivers bundles in pairs.
  localparam int unsigned PairSize       = 2;

endpackage

// File: rtl/warp_issue_queue.sv
// Bundle FIFO between decode (writes pairs) and issue (reads up to two oldest entries).
// Head entries are combinational reads of the array; there is no enqueue bypass.
module warp_issue_queue
  import warp_issue_queue_pkg::*;
#(
  parameter int unsigned BUNDLE_W = BundleWDefault,
  parameter int unsigned DEPTH    = DepthDefault
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_flush,
  output logic                o_input_ready,
  input  logic                i_input_valid,
  input  logic [BUNDLE_W-1:0] i_bundle0,
  input  logic [BUNDLE_W-1:0] i_bundle1,
  output logic [BUNDLE_W-1:0] o_bundle0,
  output logic [BUNDLE_W-1:0] o_bundle1,
  output logic                o_bundle0_valid,
  output logic                o_bundle1_valid,
  input  logic                i_dispatch0,
  input  logic                i_dispatch1
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef logic [PtrW-1:0] ptr_t;
  typedef logic [PtrW:0]   cnt_t;

  logic [BUNDLE_W-1:0] mem_q [DEPTH];
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t wr_ptr_q, wr_ptr_d;
  cnt_t count_q, count_d;

  ptr_t rd_ptr_p1;
  ptr_t wr_ptr_p1;
  logic enq;
  logic deq0;
  logic deq1;
  logic bad_dispatch;

  assign rd_ptr_p1 = rd_ptr_q + ptr_t'(1);
  assign wr_ptr_p1 = wr_ptr_q + ptr_t'(1);

  // Ready looks only at the registered count, so issue never combinationally gates decode.
  assign o_input_ready = (count_q <= cnt_t'(DEPTH - PairSize));

  assign o_bundle0       = mem_q[rd_ptr_q];
  assign o_bundle1       = mem_q[rd_ptr_p1];
  assign o_bundle0_valid = (count_q >= cnt_t'(1));
  assign o_bundle1_valid = (count_q >= cnt_t'(2));

  assign enq  = i_input_valid && o_input_ready && !i_flush && !i_rst;
  assign deq0 = i_dispatch0 && o_bundle0_valid;
  assign deq1 = i_dispatch1 && deq0 && o_bundle1_valid;

  assign bad_dispatch = (i_dispatch1 && !i_dispatch0) ||
                        (i_dispatch0 && !o_bundle0_valid) ||
                        (i_dispatch1 && !o_bundle1_valid);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(PairSize);
      end
      rd_ptr_d = rd_ptr_q + ptr_t'(deq0) + ptr_t'(deq1);
      count_d  = count_q + (enq ? cnt_t'(PairSize) : cnt_t'(0)) - cnt_t'(deq0) - cnt_t'(deq1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; valids mask stale contents.
  always_ff @(posedge i_clk) begin
    if (enq) begin
      mem_q[wr_ptr_q]  <= i_bundle0;
      mem_q[wr_ptr_p1] <= i_bundle1;
    end
  end

  // Illegal dispatch patterns are ignored by the datapath but reported in simulation.
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush) begin
      assert (!bad_dispatch)
      else $warning("warp_issue_queue: dispatch on invalid slot or dispatch1 without dispatch0");
    end
  end

endmodule

// File: tb/tb_warp_issue_queue.sv
// Directed bench for warp_issue_queue: one task per scenario with inline checks.
module tb_warp_issue_queue;

  localparam int unsigned BW = 32;
  localparam int unsigned DP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          input_ready;
  logic          input_valid;
  logic [BW-1:0] in_b0;
  logic [BW-1:0] in_b1;
  logic [BW-1:0] b0;
  logic [BW-1:0] b1;
  logic          v0;
  logic          v1;
  logic          d0;
  logic          d1;

  int checks = 0;
  int errors = 0;

  warp_issue_queue #(
    .BUNDLE_W (BW),
    .DEPTH    (DP)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_flush         (flush),
    .o_input_ready   (input_ready),
    .i_input_valid   (input_valid),
    .i_bundle0       (in_b0),
    .i_bundle1       (in_b1),
    .o_bundle0       (b0),
    .o_bundle1       (b1),
    .o_bundle0_valid (v0),
    .o_bundle1_valid (v1),
    .i_dispatch0     (d0),
    .i_dispatch1     (d1)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    input_valid = 1'b0;
    d0          = 1'b0;
    d1          = 1'b0;
  endtask

  task automatic clear_queue();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic push_pair(input logic [BW-1:0] a, input logic [BW-1:0] b);
    in_b0       = a;
    in_b1       = b;
    input_valid = 1'b1;
    step();
    input_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    in_b0 = '0;
    in_b1 = '0;
    step();
    step();
    rst = 1'b0;
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", input_ready); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL rst_v0 got %b want 0", v0); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL rst_v1 got %b want 0", v1); end
    // Mid-stream reset beats a flush and a presented pair.
    push_pair(32'h0000_1111, 32'h0000_2222);
    rst         = 1'b1;
    flush       = 1'b1;
    input_valid = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    step();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL midrst_v0 got %b want 0", v0); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", input_ready); end
  endtask

  task automatic test_enqueue_one();
    clear_queue();
    in_b0       = 32'h0000_000A;
    in_b1       = 32'h0000_000B;
    input_valid = 1'b1;
    #1;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL no_bypass got %b want 0", v0); end
    step();
    input_valid = 1'b0;
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL enq_v0 got %b want 1", v0); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL enq_v1 got %b want 1", v1); end
    checks++; if (b0 !== 32'h0000_000A) begin errors++; $display("FAIL enq_b0 got %h want %h", b0, 32'h0000_000A); end
    checks++; if (b1 !== 32'h0000_000B) begin errors++; $display("FAIL enq_b1 got %h want %h", b1, 32'h0000_000B); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL enq_ready got %b want 1", input_ready); end
  endtask

  task automatic test_partial_dispatch();
    clear_queue();
    push_pair(32'hA, 32'hB);
    push_pair(32'hC, 32'hD);
    d0 = 1'b1;
    step();
    d0 = 1'b0;
    checks++; if (b0 !== 32'hB) begin errors++; $display("FAIL part1_b0 got %h want %h", b0, 32'hB); end
    checks++; if (b1 !== 32'hC) begin errors++; $display("FAIL part1_b1 got %h want %h", b1, 32'hC); end
    d0 = 1'b1;
    d1 = 1'b1;
    step();
    idle_inputs();
    checks++; if (b0 !== 32'hD) begin errors++; $display("FAIL part2_b0 got %h want %h", b0, 32'hD); end
    checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL part2_v0 got %b want 1", v0); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL part2_v1 got %b want 0", v1); end
  endtask

  task automatic test_fill();
    logic [BW-1:0] base;
    base = 32'hF000_0000;
    clear_queue();
    for (int i = 0; i < 4; i++) begin
      push_pair(base + BW'(2 * i), base + BW'(2 * i + 1));
      if (i == 2) begin
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL fill6_ready got %b want 1", input_ready); end
      end
    end
    checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL fill8_ready got %b want 0", input_ready); end
    // Fifth pair held by decode while full must not be written.
    in_b0       = base + BW'(8);
    in_b1       = base + BW'(9);
    input_valid = 1'b1;
    step();
    checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b want 0", input_ready); end
    checks++; if (b0 !== base) begin errors++; $display("FAIL full_head got %h want %h", b0, base); end
    d0 = 1'b1;
    d1 = 1'b1;
    step();
    idle_inputs();
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL ready_back got %b want 1", input_ready); end
    for (int j = 1; j < 4; j++) begin
      checks++; if (b0 !== base + BW'(2 * j)) begin errors++; $display("FAIL drain_b0 got %h want %h", b0, base + BW'(2 * j)); end
      checks++; if (b1 !== base + BW'(2 * j + 1)) begin errors++; $display("FAIL drain_b1 got %h want %h", b1, base + BW'(2 * j + 1)); end
      d0 = 1'b1;
      d1 = 1'b1;
      step();
      idle_inputs();
    end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", v0); end
  endtask

  task automatic test_wrap();
    logic [BW-1:0] sb[$];
    int unsigned   seq;
    bit            do_enq;
    seq = 0;
    clear_queue();
    for (int c = 0; c < 20; c++) begin
      checks++; if (input_ready !== (sb.size() <= 6)) begin errors++; $display("FAIL wrap_ready c=%0d got %b want %b", c, input_ready, sb.size() <= 6); end
      checks++; if (v0 !== (sb.size() >= 1)) begin errors++; $display("FAIL wrap_v0 c=%0d got %b want %b", c, v0, sb.size() >= 1); end
      checks++; if (v1 !== (sb.size() >= 2)) begin errors++; $display("FAIL wrap_v1 c=%0d got %b want %b", c, v1, sb.size() >= 2); end
      if (sb.size() >= 1) begin
        checks++; if (b0 !== sb[0]) begin errors++; $display("FAIL wrap_b0 c=%0d got %h want %h", c, b0, sb[0]); end
      end
      if (sb.size() >= 2) begin
        checks++; if (b1 !== sb[1]) begin errors++; $display("FAIL wrap_b1 c=%0d got %h want %h", c, b1, sb[1]); end
      end
      do_enq      = (sb.size() <= 6);
      input_valid = 1'b1;
      in_b0       = 32'hA000_0000 + seq;
      in_b1       = 32'hA000_0000 + seq + 1;
      d0          = (sb.size() >= 1);
      d1          = (c % 2 == 1) && (sb.size() >= 2);
      step();
      if (d0) void'(sb.pop_front());
      if (d1) void'(sb.pop_front());
      if (do_enq) begin
        sb.push_back(32'hA000_0000 + seq);
        sb.push_back(32'hA000_0000 + seq + 1);
        seq += 2;
      end
    end
    idle_inputs();
    checks++; if (b0 !== sb[0]) begin errors++; $display("FAIL wrap_final got %h want %h", b0, sb[0]); end
  endtask

  task automatic test_flush();
    clear_queue();
    push_pair(32'hC0, 32'hC1);
    push_pair(32'hC2, 32'hC3);
    push_pair(32'hC4, 32'hC5);
    d0 = 1'b1;
    step();
    d0 = 1'b0;
    checks++; if (b0 !== 32'hC1) begin errors++; $display("FAIL pre_flush_b0 got %h want %h", b0, 32'hC1); end
    flush       = 1'b1;
    input_valid = 1'b1;
    in_b0       = 32'hE0;
    in_b1       = 32'hE1;
    d0          = 1'b1;
    d1          = 1'b1;
    step();
    idle_inputs();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL flush_v0 got %b want 0", v0); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL flush_v1 got %b want 0", v1); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", input_ready); end
    step();
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL flush_drop got %b want 0", v0); end
    push_pair(32'hF0, 32'hF1);
    checks++; if (b0 !== 32'hF0) begin errors++; $display("FAIL post_flush_b0 got %h want %h", b0, 32'hF0); end
    checks++; if (b1 !== 32'hF1) begin errors++; $display("FAIL post_flush_b1 got %h want %h", b1, 32'hF1); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL post_flush_v1 got %b want 1", v1); end
  endtask

  task automatic test_illegal_dispatch();
    clear_queue();
    push_pair(32'h50, 32'h51);
    d1 = 1'b1;
    step();
    d1 = 1'b0;
    checks++; if (b0 !== 32'h50) begin errors++; $display("FAIL d1only_b0 got %h want %h", b0, 32'h50); end
    checks++; if (b1 !== 32'h51) begin errors++; $display("FAIL d1only_b1 got %h want %h", b1, 32'h51); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL d1only_v1 got %b want 1", v1); end
    clear_queue();
    d0 = 1'b1;
    step();
    d0 = 1'b0;
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL empty_deq_v0 got %b want 0", v0); end
    checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL empty_deq_ready got %b want 1", input_ready); end
    push_pair(32'h60, 32'h61);
    checks++; if (b0 !== 32'h60) begin errors++; $display("FAIL empty_deq_head got %h want %h", b0, 32'h60); end
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL empty_deq_v1 got %b want 1", v1); end
    push_pair(32'h62, 32'h63);
    push_pair(32'h64, 32'h65);
    push_pair(32'h66, 32'h67);
    checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL empty_deq_full got %b want 0", input_ready); end
  endtask

  initial begin
    test_reset();
    test_enqueue_one();
    test_partial_dispatch();
    test_fill();
    test_wrap();
    test_flush();
    test_illegal_dispatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
